memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_if.sv | 15 +
 rtl/memory_stage.sv | 134 +++++++++++++
 tb/tb_memory_stage.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Data-cache bus between the memory stage (master) and the data cache (slave).
// The stage drives requests and address/store data; the cache returns hit and read data.
interface memory_stage_if;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic        dhit;
   logic [31:0] dmemload;

   modport master (output dmemREN, dmemWEN, dmemaddr, dmemstore,
                   input  dhit, dmemload);
   modport slave  (input  dmemREN, dmemWEN, dmemaddr, dmemstore,
                   output dhit, dmemload);
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues data-cache requests, stalls until the hit,
// extracts sub-word load results and holds the MEM/WB pipeline register.
module memory_stage (
   input  logic                  CLK,
   input  logic                  nRST,
   memory_stage_if.master        dbus,
   input  logic                  ex_valid,
   input  logic                  ex_memRead,
   input  logic                  ex_memWrite,
   input  logic                  ex_regWen,
   input  logic [4:0]            ex_wreg,
   input  logic [31:0]           ex_aluOut,
   input  logic [31:0]           ex_storeData,
   input  logic [31:0]           ex_npc,
   input  logic                  ex_jal,
   input  logic                  ex_ldtype,
   input  logic [1:0]            ex_ldsize,
   input  logic                  ex_ldsigned,
   input  logic                  flush,
   output logic                  mem_stall,
   output logic                  wb_Reg_Wen,
   output logic [4:0]            wb_wreg,
   output logic [31:0]           wb_memReg,
   output logic [31:0]           wb_extOut,
   output logic [31:0]           wb_npc,
   output logic                  wb_jaltype,
   output logic                  wb_ldtype
);
   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

   state_e      r_state;
   state_e      w_next_state;
   logic        w_mem_op;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_capture;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_ext;

   logic        r_wb_reg_wen;
   logic [4:0]  r_wb_wreg;
   logic [31:0] r_wb_mem_reg;
   logic [31:0] r_wb_ext_out;
   logic [31:0] r_wb_npc;
   logic        r_wb_jaltype;
   logic        r_wb_ldtype;

   // A read+write combination behaves as a load; flush removes the op outright.
   assign w_is_load  = ex_memRead;
   assign w_is_store = ex_memWrite & ~ex_memRead;
   assign w_mem_op   = ex_valid & (ex_memRead | ex_memWrite) & ~flush;

   assign mem_stall       = nRST & w_mem_op & ~dbus.dhit;
   assign dbus.dmemaddr   = {ex_aluOut[31:2], 2'b00};
   assign dbus.dmemstore  = ex_storeData;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_mem_op && !dbus.dhit) w_next_state = S_WAIT;
         S_WAIT:  if (dbus.dhit || !w_mem_op) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Requests rise in the first cycle from IDLE and are held through WAIT.
   always_comb begin
      dbus.dmemREN = 1'b0;
      dbus.dmemWEN = 1'b0;
      case (r_state)
         S_IDLE, S_WAIT: begin
            dbus.dmemREN = nRST & w_mem_op & w_is_load;
            dbus.dmemWEN = nRST & w_mem_op & w_is_store;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_byte = dbus.dmemload[7:0];
      case (ex_aluOut[1:0])
         2'd0: w_byte = dbus.dmemload[7:0];
         2'd1: w_byte = dbus.dmemload[15:8];
         2'd2: w_byte = dbus.dmemload[23:16];
         2'd3: w_byte = dbus.dmemload[31:24];
         default: ;
      endcase
      w_half = ex_aluOut[1] ? dbus.dmemload[31:16] : dbus.dmemload[15:0];
      case (ex_ldsize)
         2'b00:   w_load_ext = ex_ldsigned ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
         2'b01:   w_load_ext = ex_ldsigned ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
         default: w_load_ext = dbus.dmemload;
      endcase
   end

   // Anything not captured (bubble, flush, stall) enters MEM/WB as all zeros.
   assign w_capture = ex_valid & ~flush & ~mem_stall;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_wb_reg_wen <= 1'b0;
         r_wb_wreg    <= '0;
         r_wb_mem_reg <= '0;
         r_wb_ext_out <= '0;
         r_wb_npc     <= '0;
         r_wb_jaltype <= 1'b0;
         r_wb_ldtype  <= 1'b0;
      end else begin
         r_wb_reg_wen <= w_capture & ex_regWen & ~w_is_store;
         r_wb_wreg    <= w_capture ? ex_wreg : '0;
         r_wb_mem_reg <= w_capture ? (w_is_load ? dbus.dmemload : ex_aluOut) : '0;
         r_wb_ext_out <= (w_capture && w_is_load) ? w_load_ext : '0;
         r_wb_npc     <= w_capture ? ex_npc : '0;
         r_wb_jaltype <= w_capture & ex_jal;
         r_wb_ldtype  <= w_capture & ex_ldtype;
      end
   end

   assign wb_Reg_Wen = r_wb_reg_wen;
   assign wb_wreg    = r_wb_wreg;
   assign wb_memReg  = r_wb_mem_reg;
   assign wb_extOut  = r_wb_ext_out;
   assign wb_npc     = r_wb_npc;
   assign wb_jaltype = r_wb_jaltype;
   assign wb_ldtype  = r_wb_ldtype;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: single-cycle vector table plus hand-written
// sequences for multi-cycle misses, stores, flush-in-WAIT and asynchronous reset.
module tb_memory_stage;
   logic        CLK;
   logic        nRST;
   logic        ex_valid, ex_memRead, ex_memWrite, ex_regWen;
   logic [4:0]  ex_wreg;
   logic [31:0] ex_aluOut, ex_storeData, ex_npc;
   logic        ex_jal, ex_ldtype;
   logic [1:0]  ex_ldsize;
   logic        ex_ldsigned, flush;
   logic        mem_stall, wb_Reg_Wen;
   logic [4:0]  wb_wreg;
   logic [31:0] wb_memReg, wb_extOut, wb_npc;
   logic        wb_jaltype, wb_ldtype;

   int checks   = 0;
   int failures = 0;

   memory_stage_if bus ();

   memory_stage dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .dbus         (bus.master),
      .ex_valid     (ex_valid),
      .ex_memRead   (ex_memRead),
      .ex_memWrite  (ex_memWrite),
      .ex_regWen    (ex_regWen),
      .ex_wreg      (ex_wreg),
      .ex_aluOut    (ex_aluOut),
      .ex_storeData (ex_storeData),
      .ex_npc       (ex_npc),
      .ex_jal       (ex_jal),
      .ex_ldtype    (ex_ldtype),
      .ex_ldsize    (ex_ldsize),
      .ex_ldsigned  (ex_ldsigned),
      .flush        (flush),
      .mem_stall    (mem_stall),
      .wb_Reg_Wen   (wb_Reg_Wen),
      .wb_wreg      (wb_wreg),
      .wb_memReg    (wb_memReg),
      .wb_extOut    (wb_extOut),
      .wb_npc       (wb_npc),
      .wb_jaltype   (wb_jaltype),
      .wb_ldtype    (wb_ldtype)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        valid, rd, wr, regwen;
      logic [4:0]  wreg;
      logic [31:0] alu, sdata, npc;
      logic        jal, ldtype;
      logic [1:0]  ldsize;
      logic        ldsigned, flush, dhit;
      logic [31:0] load;
      logic        e_ren, e_wen, e_stall, e_wbwen;
      logic [4:0]  e_wreg;
      logic [31:0] e_memreg, e_ext, e_npc;
      logic        e_jal, e_ldtype;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      ex_valid     = v.valid;
      ex_memRead   = v.rd;
      ex_memWrite  = v.wr;
      ex_regWen    = v.regwen;
      ex_wreg      = v.wreg;
      ex_aluOut    = v.alu;
      ex_storeData = v.sdata;
      ex_npc       = v.npc;
      ex_jal       = v.jal;
      ex_ldtype    = v.ldtype;
      ex_ldsize    = v.ldsize;
      ex_ldsigned  = v.ldsigned;
      flush        = v.flush;
      bus.dhit     = v.dhit;
      bus.dmemload = v.load;
   endtask

   task automatic idle();
      ex_valid = 0; ex_memRead = 0; ex_memWrite = 0; ex_regWen = 0;
      ex_wreg = '0; ex_aluOut = '0; ex_storeData = '0; ex_npc = '0;
      ex_jal = 0; ex_ldtype = 0; ex_ldsize = 2'b00; ex_ldsigned = 0; flush = 0;
      bus.dhit = 0; bus.dmemload = '0;
   endtask

   task automatic load_op(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                          input logic [4:0] rd_reg);
      idle();
      ex_valid = 1; ex_memRead = 1; ex_regWen = 1; ex_ldtype = 1;
      ex_wreg = rd_reg; ex_aluOut = addr; ex_ldsize = size; ex_ldsigned = sgn;
      ex_npc = 32'h0000_0300;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      //        valid rd wr rwen wreg  alu            sdata          npc            jal ldt size   sgn fl dhit load           | ren wen stl wbw wreg  memreg         ext            npc            jal ldt
      vecs[0]  = '{1, 0, 0, 1, 5'd5,  32'h1234_5678, 32'h0,         32'h0000_0100, 0, 0, 2'b00, 0, 0, 0, 32'h0,          0, 0, 0, 1, 5'd5,  32'h1234_5678, 32'h0,         32'h0000_0100, 0, 0};
      vecs[1]  = '{0, 0, 0, 1, 5'd3,  32'h0000_AAAA, 32'h0,         32'h0000_0104, 0, 0, 2'b00, 0, 0, 0, 32'h0,          0, 0, 0, 0, 5'd0,  32'h0,         32'h0,         32'h0,         0, 0};
      vecs[2]  = '{1, 1, 0, 1, 5'd8,  32'h0000_2002, 32'h0,         32'h0000_0044, 0, 1, 2'b01, 0, 0, 1, 32'hBEEF_1234,  1, 0, 0, 1, 5'd8,  32'hBEEF_1234, 32'h0000_BEEF, 32'h0000_0044, 0, 1};
      vecs[3]  = '{1, 1, 0, 1, 5'd9,  32'h0000_3001, 32'h0,         32'h0000_0048, 0, 1, 2'b00, 1, 0, 1, 32'h0000_8000,  1, 0, 0, 1, 5'd9,  32'h0000_8000, 32'hFFFF_FF80, 32'h0000_0048, 0, 1};
      vecs[4]  = '{1, 1, 0, 1, 5'd10, 32'h0000_4002, 32'h0,         32'h0000_004C, 0, 1, 2'b00, 0, 0, 1, 32'h00AB_0000,  1, 0, 0, 1, 5'd10, 32'h00AB_0000, 32'h0000_00AB, 32'h0000_004C, 0, 1};
      vecs[5]  = '{1, 1, 0, 1, 5'd11, 32'h0000_5000, 32'h0,         32'h0000_0050, 0, 1, 2'b01, 1, 0, 1, 32'h1111_8001,  1, 0, 0, 1, 5'd11, 32'h1111_8001, 32'hFFFF_8001, 32'h0000_0050, 0, 1};
      vecs[6]  = '{1, 1, 0, 1, 5'd12, 32'h0000_6004, 32'h0,         32'h0000_0054, 0, 1, 2'b10, 0, 0, 1, 32'hCAFE_BABE,  1, 0, 0, 1, 5'd12, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'h0000_0054, 0, 1};
      vecs[7]  = '{1, 1, 0, 1, 5'd13, 32'h0000_7001, 32'h0,         32'h0000_0058, 0, 1, 2'b11, 1, 0, 1, 32'h8000_0001,  1, 0, 0, 1, 5'd13, 32'h8000_0001, 32'h8000_0001, 32'h0000_0058, 0, 1};
      vecs[8]  = '{1, 0, 0, 1, 5'd31, 32'h0000_01F0, 32'h0,         32'h0000_0040, 1, 0, 2'b00, 0, 0, 0, 32'h0,          0, 0, 0, 1, 5'd31, 32'h0000_01F0, 32'h0,         32'h0000_0040, 1, 0};
      vecs[9]  = '{1, 0, 1, 1, 5'd2,  32'h0000_0007, 32'hDEAD_BEEF, 32'h0000_005C, 0, 0, 2'b00, 0, 0, 1, 32'h0,          0, 1, 0, 0, 5'd2,  32'h0000_0007, 32'h0,         32'h0000_005C, 0, 0};
      vecs[10] = '{1, 1, 1, 1, 5'd14, 32'h0000_8000, 32'h55AA_55AA, 32'h0000_0060, 0, 1, 2'b10, 0, 0, 1, 32'h1234_5678,  1, 0, 0, 1, 5'd14, 32'h1234_5678, 32'h1234_5678, 32'h0000_0060, 0, 1};
      vecs[11] = '{1, 0, 0, 1, 5'd4,  32'h0000_9999, 32'h0,         32'h0000_0064, 0, 0, 2'b00, 0, 1, 0, 32'h0,          0, 0, 0, 0, 5'd0,  32'h0,         32'h0,         32'h0,         0, 0};
      vecs[12] = '{1, 1, 0, 1, 5'd6,  32'h0000_A000, 32'h0,         32'h0000_0068, 0, 1, 2'b10, 0, 1, 0, 32'hFFFF_FFFF,  0, 0, 0, 0, 5'd0,  32'h0,         32'h0,         32'h0,         0, 0};
      vecs[13] = '{1, 1, 0, 1, 5'd15, 32'h0000_B000, 32'h0,         32'h0000_006C, 0, 1, 2'b00, 1, 0, 1, 32'h0000_007F,  1, 0, 0, 1, 5'd15, 32'h0000_007F, 32'h0000_007F, 32'h0000_006C, 0, 1};
      vecs[14] = '{1, 1, 0, 1, 5'd16, 32'h0000_C003, 32'h0,         32'h0000_0070, 0, 1, 2'b00, 0, 0, 1, 32'h8000_0000,  1, 0, 0, 1, 5'd16, 32'h8000_0000, 32'h0000_0080, 32'h0000_0070, 0, 1};

      // Reset held with a live load miss on the inputs: everything must stay quiet.
      nRST = 1'b0;
      load_op(32'h0000_1003, 2'b00, 1'b1, 5'd7);
      #2;
      check("rst.ren",   bus.dmemREN, 0);
      check("rst.wen",   bus.dmemWEN, 0);
      check("rst.stall", mem_stall,   0);
      tick();
      tick();
      check("rst.wb_wen", wb_Reg_Wen, 0);
      check("rst.wb_mem", wb_memReg,  0);
      check("rst.wb_ext", wb_extOut,  0);
      check("rst.wb_npc", wb_npc,     0);
      check("rst.wb_wr",  wb_wreg,    0);
      idle();
      nRST = 1'b1;
      tick();

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i]);
         #2;
         check($sformatf("v%0d.ren",   i), bus.dmemREN,   vecs[i].e_ren);
         check($sformatf("v%0d.wen",   i), bus.dmemWEN,   vecs[i].e_wen);
         check($sformatf("v%0d.stall", i), mem_stall,     vecs[i].e_stall);
         check($sformatf("v%0d.addr",  i), bus.dmemaddr,  vecs[i].alu & 32'hFFFF_FFFC);
         check($sformatf("v%0d.store", i), bus.dmemstore, vecs[i].sdata);
         tick();
         check($sformatf("v%0d.wb_wen", i), wb_Reg_Wen, vecs[i].e_wbwen);
         check($sformatf("v%0d.wb_wr",  i), wb_wreg,    vecs[i].e_wreg);
         check($sformatf("v%0d.wb_mem", i), wb_memReg,  vecs[i].e_memreg);
         check($sformatf("v%0d.wb_ext", i), wb_extOut,  vecs[i].e_ext);
         check($sformatf("v%0d.wb_npc", i), wb_npc,     vecs[i].e_npc);
         check($sformatf("v%0d.wb_jal", i), wb_jaltype, vecs[i].e_jal);
         check($sformatf("v%0d.wb_ldt", i), wb_ldtype,  vecs[i].e_ldtype);
      end

      // Signed byte load missing for three cycles, then hitting.
      load_op(32'h0000_1003, 2'b00, 1'b1, 5'd7);
      bus.dmemload = 32'h80FF_FF00;
      for (int c = 0; c < 3; c++) begin
         #2;
         check($sformatf("miss.stall%0d", c), mem_stall,   1);
         check($sformatf("miss.ren%0d",   c), bus.dmemREN, 1);
         tick();
         check($sformatf("miss.wb_wen%0d", c), wb_Reg_Wen, 0);
      end
      bus.dhit = 1'b1;
      #2;
      check("miss.hit_stall", mem_stall,   0);
      check("miss.hit_ren",   bus.dmemREN, 1);
      tick();
      check("miss.wb_ext", wb_extOut,  32'hFFFF_FF80);
      check("miss.wb_wen", wb_Reg_Wen, 1);
      check("miss.wb_mem", wb_memReg,  32'h80FF_FF00);
      idle();
      #2;
      check("miss.after_ren", bus.dmemREN, 0);
      tick();

      // Store waiting two cycles for the cache.
      idle();
      ex_valid = 1; ex_memWrite = 1; ex_regWen = 1; ex_wreg = 5'd3;
      ex_aluOut = 32'h0000_0007; ex_storeData = 32'hDEAD_BEEF;
      for (int c = 0; c < 2; c++) begin
         #2;
         check($sformatf("st.wen%0d",   c), bus.dmemWEN,   1);
         check($sformatf("st.ren%0d",   c), bus.dmemREN,   0);
         check($sformatf("st.addr%0d",  c), bus.dmemaddr,  32'h0000_0004);
         check($sformatf("st.data%0d",  c), bus.dmemstore, 32'hDEAD_BEEF);
         check($sformatf("st.stall%0d", c), mem_stall,     1);
         tick();
      end
      bus.dhit = 1'b1;
      #2;
      check("st.hit_wen",   bus.dmemWEN, 1);
      check("st.hit_stall", mem_stall,   0);
      tick();
      check("st.wb_wen", wb_Reg_Wen, 0);
      idle();
      #2;
      check("st.after_wen", bus.dmemWEN, 0);
      tick();

      // Flush arriving in WAIT together with the hit.
      load_op(32'h0000_2000, 2'b10, 1'b0, 5'd9);
      #2;
      check("fl.stall", mem_stall, 1);
      tick();
      flush = 1'b1;
      bus.dhit = 1'b1;
      bus.dmemload = 32'h1357_9BDF;
      #2;
      check("fl.ren",   bus.dmemREN, 0);
      check("fl.wen",   bus.dmemWEN, 0);
      check("fl.stall", mem_stall,   0);
      tick();
      check("fl.wb_wen", wb_Reg_Wen, 0);
      check("fl.wb_mem", wb_memReg,  0);
      check("fl.wb_ext", wb_extOut,  0);
      check("fl.wb_wr",  wb_wreg,    0);
      idle();
      tick();

      // Asynchronous clear of a populated MEM/WB register, between clock edges.
      idle();
      ex_valid = 1; ex_regWen = 1; ex_wreg = 5'd7; ex_aluOut = 32'h0000_0077; ex_npc = 32'h0000_0200;
      tick();
      check("ar.wb_wen_set", wb_Reg_Wen, 1);
      #2;
      nRST = 1'b0;
      #1;
      check("ar.wb_wen", wb_Reg_Wen, 0);
      check("ar.wb_wr",  wb_wreg,    0);
      check("ar.wb_npc", wb_npc,     0);
      check("ar.wb_mem", wb_memReg,  0);
      idle();
      #1;
      nRST = 1'b1;
      tick();

      // Reset pulsed mid-WAIT: request aborts and nothing is captured afterwards.
      load_op(32'h0000_4000, 2'b10, 1'b0, 5'd20);
      tick();
      check("rw.stall_wait", mem_stall, 1);
      #2;
      nRST = 1'b0;
      #1;
      check("rw.ren",   bus.dmemREN, 0);
      check("rw.stall", mem_stall,   0);
      bus.dhit = 1'b1;
      bus.dmemload = 32'hA5A5_A5A5;
      tick();
      check("rw.wb_wen", wb_Reg_Wen, 0);
      check("rw.wb_ext", wb_extOut,  0);
      idle();
      nRST = 1'b1;
      #2;
      check("rw.rel_ren", bus.dmemREN, 0);
      tick();
      check("rw.rel_wb_wen", wb_Reg_Wen, 0);
      check("rw.rel_wb_mem", wb_memReg,  0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
